// File: rtl/pdm_filter_ctrl_pkg.sv
// Shared types and constants for the PDM filter sequencer.
package pdm_pkg;

    localparam int unsigned LEN_W     = 8;
    localparam int unsigned DEF_DIV   = 4;
    localparam int unsigned DEF_DECIM = 16;
    localparam int unsigned MIN_DIV   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        WARM  = 2'd2,
        RUN   = 2'd3
    } state_e;

endpackage

// File: rtl/pdm_filter_ctrl_if.sv
// Configuration handshake and decimated output stream of the PDM sequencer.
// master: register/config host and downstream consumer; slave: the sequencer.
interface pdm_filter_ctrl_if #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned DEC_W = 8
);
    logic                       cfg_valid;
    logic                       cfg_ready;
    logic [pdm_pkg::LEN_W-1:0]  cfg_length;
    logic [DEC_W-1:0]           cfg_decim;
    logic [DIV_W-1:0]           cfg_div;
    logic                       out_valid;
    logic                       out_ready;
    logic [pdm_pkg::LEN_W-1:0]  out_data;

    modport master (
        output cfg_valid, cfg_length, cfg_decim, cfg_div, out_ready,
        input  cfg_ready, out_valid, out_data
    );

    modport slave (
        input  cfg_valid, cfg_length, cfg_decim, cfg_div, out_ready,
        output cfg_ready, out_valid, out_data
    );
endinterface

// File: rtl/pdm_filter_ctrl_clk_div.sv
// Microphone clock divider: counter 0..div-1, clock high for the first div/2 counts,
// one-cycle sample strobe on the last count. hold parks the counter at 0.
module pdm_clk_div #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic [DIV_W-1:0] div,
    output logic             pdm_clk,
    output logic             pdm_sample_en
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             last_c;

    // Next count; >= keeps the counter bounded even if div shrinks mid-period
    always_comb begin
        last_c = (cnt_q >= (div - DIV_W'(1)));
        cnt_d  = cnt_q + DIV_W'(1);
        if (hold || last_c) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Clock and strobe decode; both silent while held
    always_comb begin
        pdm_clk       = !hold && (cnt_q < (div >> 1));
        pdm_sample_en = !hold && last_c;
    end

endmodule

// File: rtl/pdm_filter_ctrl.sv
// PDM boxcar filter sequencer: config latch, flush/warm-up FSM, decimator and
// valid/ready output register with sticky overrun.
module pdm_filter_ctrl
    import pdm_pkg::*;
#(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned DEC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    pdm_filter_ctrl_if.slave  bus,
    output logic              pdm_clk,
    output logic              pdm_sample_en,
    output logic [LEN_W-1:0]  filt_length,
    output logic              filt_flush,
    input  logic [LEN_W-1:0]  filt_sum,
    output logic              overrun
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [DEC_W-1:0]   decim_q, decim_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [LEN_W-1:0]   warm_q, warm_d;
    logic [DEC_W-1:0]   dec_cnt_q, dec_cnt_d;
    logic               cap_q, cap_d;
    logic               out_valid_q, out_valid_d;
    logic [LEN_W-1:0]   out_data_q, out_data_d;
    logic               ovr_q, ovr_d;

    logic               ready_c;
    logic               hold_c;
    logic               flush_c;
    logic               accept_c;
    logic               strobe_c;
    logic               pdm_clk_c;

    pdm_clk_div #(.DIV_W(DIV_W)) u_clk_div (
        .clk           (clk),
        .rst           (rst),
        .hold          (hold_c),
        .div           (div_q),
        .pdm_clk       (pdm_clk_c),
        .pdm_sample_en (strobe_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept_c) state_d = FLUSH;
            FLUSH: state_d = WARM;
            WARM:  if (strobe_c && (warm_q == (len_q - LEN_W'(1)))) state_d = RUN;
            RUN:   if (accept_c) state_d = FLUSH;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded controls
    always_comb begin
        ready_c  = (state_q == IDLE) || (state_q == RUN);
        hold_c   = (state_q == IDLE) || (state_q == FLUSH);
        flush_c  = hold_c;
        accept_c = bus.cfg_valid && ready_c && !rst;
    end

    // Config latch, warm-up/decimation counters and output register next values
    always_comb begin
        len_d       = len_q;
        decim_d     = decim_q;
        div_d       = div_q;
        warm_d      = warm_q;
        dec_cnt_d   = dec_cnt_q;
        cap_d       = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ovr_d       = ovr_q;

        if (accept_c) begin
            len_d   = (bus.cfg_length == '0) ? LEN_W'(1) : bus.cfg_length;
            decim_d = (bus.cfg_decim == '0) ? DEC_W'(1) : bus.cfg_decim;
            div_d   = (bus.cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : bus.cfg_div;
        end

        if (state_q == FLUSH) begin
            warm_d    = '0;
            dec_cnt_d = '0;
        end else if ((state_q == WARM) && strobe_c) begin
            warm_d = warm_q + LEN_W'(1);
        end else if ((state_q == RUN) && strobe_c && !accept_c) begin
            if (dec_cnt_q >= (decim_q - DEC_W'(1))) begin
                dec_cnt_d = '0;
                cap_d     = 1'b1;
            end else begin
                dec_cnt_d = dec_cnt_q + DEC_W'(1);
            end
        end

        // Reconfiguration beats a pending capture; a capture into a full,
        // stalled register is dropped and flagged
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept_c) begin
            out_valid_d = 1'b0;
            ovr_d       = 1'b0;
        end else if (cap_q) begin
            if (out_valid_q && !bus.out_ready) begin
                ovr_d = 1'b1;
            end else begin
                out_data_d  = filt_sum;
                out_valid_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= LEN_W'(1);
            decim_q     <= DEC_W'(DEF_DECIM);
            div_q       <= DIV_W'(DEF_DIV);
            warm_q      <= '0;
            dec_cnt_q   <= '0;
            cap_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovr_q       <= 1'b0;
        end else begin
            len_q       <= len_d;
            decim_q     <= decim_d;
            div_q       <= div_d;
            warm_q      <= warm_d;
            dec_cnt_q   <= dec_cnt_d;
            cap_q       <= cap_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovr_q       <= ovr_d;
        end
    end

    // Outputs forced to their reset values for as long as rst is held
    always_comb begin
        pdm_clk       = pdm_clk_c && !rst;
        pdm_sample_en = strobe_c && !rst;
        filt_flush    = flush_c || rst;
        filt_length   = rst ? LEN_W'(1) : len_q;
        overrun       = ovr_q && !rst;
        bus.cfg_ready = ready_c && !rst;
        bus.out_valid = out_valid_q && !rst;
        bus.out_data  = rst ? '0 : out_data_q;
    end

endmodule

// File: tb/tb_pdm_filter_ctrl.sv
// Self-checking bench for pdm_filter_ctrl: timeline-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pdm_filter_ctrl;
    import pdm_pkg::*;

    localparam int unsigned DIV_W = 8;
    localparam int unsigned DEC_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             pdm_clk, pdm_sample_en, filt_flush, overrun;
    logic [LEN_W-1:0] filt_length, filt_sum;
    logic             rand_sum;

    int tests = 0;
    int fails = 0;

    pdm_filter_ctrl_if #(.DIV_W(DIV_W), .DEC_W(DEC_W)) bus ();

    pdm_filter_ctrl #(.DIV_W(DIV_W), .DEC_W(DEC_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .pdm_clk       (pdm_clk),
        .pdm_sample_en (pdm_sample_en),
        .filt_length   (filt_length),
        .filt_flush    (filt_flush),
        .filt_sum      (filt_sum),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // After an accepted config, cycle t=1 is the flush cycle; from t=2 the mic
    // clock runs with period div. Strobe k (k>=1) lands at t = 1 + k*div.
    // Strobes 1..len warm the filter; later strobes are decimated.
    bit               m_init = 1'b0;
    bit               m_idle;
    int               m_t;
    int               m_len, m_dec, m_div;
    bit               m_valid, m_ovr;
    logic [LEN_W-1:0] m_data;

    function automatic bit m_ready();
        return m_idle || (m_t >= 2 + m_len * m_div);
    endfunction

    function automatic bit m_running();
        return !m_idle && (m_t >= 2);
    endfunction

    function automatic int m_phase();
        return (m_t - 2) % m_div;
    endfunction

    // True in the cycle after a strobe whose run-index is a multiple of decim
    function automatic bit m_capture();
        int k;
        if (m_idle || m_t < 3) return 1'b0;
        if (((m_t - 3) % m_div) != m_div - 1) return 1'b0;
        k = (m_t - 3) / m_div + 1;
        if (k <= m_len) return 1'b0;
        return ((k - m_len) % m_dec) == 0;
    endfunction

    always @(posedge clk) begin
        bit               acc, cap, nv, no;
        logic [LEN_W-1:0] nd;
        if (rst) begin
            m_init  <= 1'b1;
            m_idle  <= 1'b1;
            m_t     <= 0;
            m_len   <= 1;
            m_dec   <= 1;
            m_div   <= 2;
            m_valid <= 1'b0;
            m_ovr   <= 1'b0;
            m_data  <= '0;
        end else if (m_init) begin
            acc = bus.cfg_valid && m_ready();
            cap = m_capture();
            nv  = m_valid;
            no  = m_ovr;
            nd  = m_data;
            if (acc) begin
                nv = 1'b0;
                no = 1'b0;
            end else if (cap) begin
                if (m_valid && !bus.out_ready) no = 1'b1;
                else begin
                    nd = filt_sum;
                    nv = 1'b1;
                end
            end else if (m_valid && bus.out_ready) begin
                nv = 1'b0;
            end
            m_valid <= nv;
            m_ovr   <= no;
            m_data  <= nd;
            if (acc) begin
                m_idle <= 1'b0;
                m_t    <= 1;
                m_len  <= (bus.cfg_length == 0) ? 1 : int'(bus.cfg_length);
                m_dec  <= (bus.cfg_decim == 0) ? 1 : int'(bus.cfg_decim);
                m_div  <= (bus.cfg_div < 2) ? 2 : int'(bus.cfg_div);
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_init) begin
            chk("cfg_ready", int'(bus.cfg_ready), int'(!rst && m_ready()));
            chk("filt_flush", int'(filt_flush), int'(rst || m_idle || m_t == 1));
            chk("filt_length", int'(filt_length), rst ? 1 : m_len);
            chk("pdm_clk", int'(pdm_clk),
                int'(!rst && m_running() && (m_phase() < m_div / 2)));
            chk("pdm_sample_en", int'(pdm_sample_en),
                int'(!rst && m_running() && (m_phase() == m_div - 1)));
            chk("out_valid", int'(bus.out_valid), int'(!rst && m_valid));
            chk("out_data", int'(bus.out_data), rst ? 0 : int'(m_data));
            chk("overrun", int'(overrun), int'(!rst && m_ovr));
        end
    end

    // Background filter-sum source
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_sum) filt_sum = LEN_W'($urandom);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer a config until it is accepted; returns just after the accepting edge
    task automatic offer(input int len, input int dec, input int div);
        int n;
        bus.cfg_length = LEN_W'(len);
        bus.cfg_decim  = DEC_W'(dec);
        bus.cfg_div    = DIV_W'(div);
        bus.cfg_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.cfg_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("offer_timeout", n, 0);
        @(posedge clk);
        #1;
        bus.cfg_valid = 1'b0;
    endtask

    initial begin
        int               n;
        int               s1;
        logic [LEN_W-1:0] d0;

        rst            = 1'b1;
        rand_sum       = 1'b0;
        filt_sum       = '0;
        bus.cfg_valid  = 1'b0;
        bus.cfg_length = '0;
        bus.cfg_decim  = '0;
        bus.cfg_div    = '0;
        bus.out_ready  = 1'b1;

        // Reset then idle
        tick(3);
        @(negedge clk);
        chk("rst_cfg_ready", int'(bus.cfg_ready), 0);
        chk("rst_flush", int'(filt_flush), 1);
        chk("rst_length", int'(filt_length), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(20);
        @(negedge clk);
        chk("idle_cfg_ready", int'(bus.cfg_ready), 1);
        chk("idle_pdm_clk", int'(pdm_clk), 0);
        chk("idle_out_valid", int'(bus.out_valid), 0);

        // Basic run: length 4, decim 2, div 4, all-ones input gives sum 4
        filt_sum = 8'd4;
        offer(4, 2, 4);
        n = 1;
        @(negedge clk);
        chk("basic_flush", int'(filt_flush), 1);
        chk("basic_length", int'(filt_length), 4);
        while (!pdm_sample_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("basic_first_strobe_lat", n, 5);
        while (!bus.out_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("basic_first_out_lat", n, 27);
        chk("basic_out_data", int'(bus.out_data), 4);
        tick(40);

        // Clamping: 0/0/1 behaves as 1/1/2
        rand_sum = 1'b1;
        offer(0, 0, 1);
        n = 0;
        while (!pdm_sample_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        s1 = n;
        @(negedge clk);
        n++;
        while (!pdm_sample_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("clamp_strobe_period", n - s1, 2);
        chk("clamp_length", int'(filt_length), 1);
        tick(20);

        // Backpressure: capture every strobe, consumer stalled
        bus.out_ready = 1'b0;
        offer(1, 1, 2);
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        d0 = bus.out_data;
        repeat (4) @(negedge clk);
        chk("bp_data_held", int'(bus.out_data), int'(d0));
        chk("bp_overrun", int'(overrun), 1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        tick(3);
        @(negedge clk);
        chk("bp_overrun_sticky", int'(overrun), 1);

        // Reconfigure mid-run with a full, overrun output
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(bus.out_valid && overrun) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reconf_pre_valid", int'(bus.out_valid), 1);
        offer(8, 3, 3);
        @(negedge clk);
        chk("reconf_flush", int'(filt_flush), 1);
        chk("reconf_length", int'(filt_length), 8);
        chk("reconf_valid", int'(bus.out_valid), 0);
        chk("reconf_overrun", int'(overrun), 0);
        chk("reconf_ready", int'(bus.cfg_ready), 0);
        n = 0;
        s1 = 0;
        while (!bus.cfg_ready && s1 < 500) begin
            @(negedge clk);
            s1++;
            if (pdm_sample_en && !bus.cfg_ready) n++;
        end
        chk("reconf_warm_strobes", n, 8);
        bus.out_ready = 1'b1;
        tick(30);

        // Reset during warm-up
        offer(5, 2, 3);
        tick(4);
        rst = 1'b1;
        @(negedge clk);
        chk("wrst_pdm_clk", int'(pdm_clk), 0);
        chk("wrst_flush", int'(filt_flush), 1);
        chk("wrst_length", int'(filt_length), 1);
        chk("wrst_ready", int'(bus.cfg_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2);
        offer(3, 1, 2);
        @(negedge clk);
        chk("wrst_restart_flush", int'(filt_flush), 1);
        chk("wrst_restart_length", int'(filt_length), 3);
        tick(30);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bus.out_ready  = ($urandom % 4) != 0;
            bus.cfg_valid  = ($urandom % 60) == 0;
            bus.cfg_length = LEN_W'($urandom % 6);
            bus.cfg_decim  = DEC_W'($urandom % 4);
            bus.cfg_div    = DIV_W'($urandom % 6);
            rst            = ($urandom % 800) == 0;
            tick(1);
        end
        rst           = 1'b0;
        bus.cfg_valid = 1'b0;
        tick(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pdm_filter_ctrl.md
Name: pdm_filter_ctrl

Overview:
- Sequencer for the PDM moving-average (boxcar) filter. Generates the microphone PDM clock and a one-cycle sample strobe that advances the filter.
- Drives the filter's window length and flush.
- After each reconfiguration it runs a flush/warm-up sequence, then decimates the filter's running sum onto a valid/ready output stream.
- Sits between the register/config interface and the filter instance; its output feeds the pitch-detect stage.

Parameters:
- DIV_W, 8, width of the clock-divide configuration/counter.
- DEC_W, 8, width of the decimation configuration/counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  controller can accept configuration
- cfg_length  in  8  filter window length in samples
- cfg_decim  in  DEC_W  output one sample per cfg_decim PDM samples
- cfg_div  in  DIV_W  system clocks per PDM bit
- pdm_clk  out  1  microphone clock
- pdm_sample_en  out  1  one-cycle strobe; the filter advances only on this cycle
- filt_length  out  8  window length driven to the filter
- filt_flush  out  1  synchronous clear of the filter shift register and sum
- filt_sum  in  8  filter running sum, valid the cycle after pdm_sample_en
- out_valid  out  1  decimated sample available
- out_ready  in  1  consumer accepts the sample
- out_data  out  8  decimated filter sum
- overrun  out  1  sticky: a sample was dropped

Behaviour:
- Reset: all state is synchronous to clk; rst is sampled on the clock edge.
  - State goes to IDLE; divider and counters are cleared.
  - pdm_clk=0, pdm_sample_en=0, filt_flush=1, filt_length=1, out_valid=0, out_data=0, overrun=0, cfg_ready=0 while rst is high.
- Configuration is latched on cfg_valid&&cfg_ready. Latched values are clamped:
  - cfg_length 0 becomes 1.
  - cfg_decim 0 becomes 1.
  - cfg_div below 2 becomes 2.
- cfg_ready=1 in IDLE and RUN, and 0 in FLUSH and WARM. Offers made in those states wait.
- Divider: the counter runs 0..div-1 in every state except IDLE and FLUSH, where it is held at 0.
  - pdm_clk=1 while the counter is below div/2 (integer division).
  - pdm_sample_en=1 when the counter equals div-1.
- States:
  - IDLE: mic clock stopped, filt_flush=1. On config accept, latch the configuration and go to FLUSH.
  - FLUSH: exactly 1 cycle with filt_flush=1 and filt_length set to the new length. Clears the warm-up and decimation counters. Next state is WARM.
  - WARM: filt_flush=0. Counts pdm_sample_en strobes; after the length-th strobe, go to RUN. No output is produced in WARM.
  - RUN:
    - Each strobe increments the decimation counter.
    - On the strobe where it equals decim-1, the counter wraps to 0 and a capture is scheduled for the next cycle.
    - The capture loads out_data from filt_sum and sets out_valid=1.
    - Config accept in RUN goes to FLUSH, clears out_valid, clears overrun and discards any scheduled capture.
- Output handshake:
  - out_valid stays high and out_data stays stable until out_valid&&out_ready.
  - Capture while out_valid=1 and out_ready=0: the new sample is dropped, out_data is kept, overrun is set.
  - Capture while out_valid=1 and out_ready=1 in the same cycle: the new sample is loaded, out_valid stays 1, no overrun.
- overrun clears only on rst or on config accept.
- Latency:
  - Config accept to first pdm_sample_en: div+1 cycles (FLUSH cycle, then counter 0..div-1).
  - Output sample: 1 cycle after the decimating strobe.
- Simultaneous events: rst has priority over everything; config accept has priority over capture.
- Width rules: all counters wrap-safe at their declared widths. filt_sum is passed through unmodified.

Decomposition:
- Shared package pdm_pkg holds:
  - state enum IDLE/FLUSH/WARM/RUN
  - LEN_W=8, DEF_DIV=4, DEF_DECIM=16, MIN_DIV=2
- One natural sub-module: pdm_clk_div. It contains the divider counter, pdm_clk and pdm_sample_en generation, with a hold input.
- The FSM, decimator and output register stay in pdm_filter_ctrl.

Test Plan:
- Reset then idle: rst for 3 cycles, then release with no cfg → cfg_ready=1, filt_flush=1, pdm_clk=0, out_valid=0 indefinitely.
- Basic run: cfg length=4, decim=2, div=4, out_ready=1, PDM input all 1s.
  - pdm_sample_en every 4 cycles, pdm_clk high 2 / low 2.
  - First out_valid after 4 warm-up strobes + 2 strobes.
  - out_data sequence 4,4,...
- Clamping: cfg length=0, decim=0, div=1 → behaves as length=1, decim=1, div=2. Strobe every 2 cycles and one output per strobe.
- Backpressure: decim=1, div=2, out_ready=0 for 10 cycles → out_data holds the first value, overrun=1 after the second capture; raising out_ready does not clear overrun.
- Reconfigure mid-run: in RUN with out_valid=1 and overrun=1, offer cfg length=8 →
  - next cycle FLUSH with filt_flush=1, filt_length=8
  - out_valid=0, overrun=0
  - cfg_ready=0 until 8 strobes have elapsed.
- Reset mid-WARM: assert rst during WARM → the next cycle shows all reset values, and a new config restarts from FLUSH.
